// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer
//
// Pulls words out of a synchronous FIFO read port and presents them
// downstream through a two-entry skid buffer with a valid/ready handshake.
// A FIFO read issued on one clock edge returns its word on read_data during
// the following cycle; that word is always captured on the next edge, so
// reads are only issued when the skid buffer is guaranteed to have room for
// it.
//
// Optional feature:
//   DRAIN_CHECKSUM_EN - when defined, adds the checksum output, a running
//                       16-bit sum of every word delivered downstream.
//
// Ports:
//   clock_read   in   single clock, all state updates on its rising edge
//   read_reset   in   asynchronous active-high reset
//   drain_enable in   allows new FIFO reads while high
//   empty        in   FIFO empty flag, synchronous to clock_read
//   read_data    in   FIFO data, valid the cycle after an accepted read
//   read_enable  out  FIFO pop request (combinational)
//   out_data     out  oldest word held in the skid buffer
//   out_valid    out  out_data holds a word
//   out_ready    in   downstream accepts out_data when out_valid is high
//   word_count   out  number of words delivered downstream (wraps)
//   checksum     out  sum of delivered words mod 2^16 (DRAIN_CHECKSUM_EN only)

module fifo_read_drainer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock_read,
    input  logic                  read_reset,
    input  logic                  drain_enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           word_count
`ifdef DRAIN_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                state;
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    logic                  pop;
    logic                  push;
    logic [1:0]            level_next;

    // The word in flight from the FIFO is pushed unconditionally, so the
    // buffer level after this edge is occ + inflight - pop. A new read is
    // only safe when that level leaves one free slot for the word it returns.
    assign out_valid  = (occ != 2'd0);
    assign out_data   = head_q;
    assign pop        = out_valid && out_ready;
    assign push       = inflight;
    assign level_next = occ + {1'b0, push} - {1'b0, pop};

    // read_reset is folded in so no pop request can escape while reset is
    // asserted, independent of how quickly the state register clears.
    assign read_enable = !read_reset && (state == RUN) && drain_enable &&
                         !empty && (level_next < 2'd2);

    // Control FSM, in-flight tracking, skid buffer storage and delivery
    // counters. head_q is always the oldest word; tail_q only holds a word
    // while occ is 2. On a simultaneous push and pop the head advances and
    // the arriving word lands directly behind it.
    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) begin
            state      <= IDLE;
            inflight   <= 1'b0;
            occ        <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            word_count <= 16'd0;
`ifdef DRAIN_CHECKSUM_EN
            checksum   <= 16'd0;
`endif
        end else begin
            inflight <= read_enable;
            occ      <= level_next;

            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_q <= read_data;
                    end else begin
                        tail_q <= read_data;
                    end
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        head_q <= tail_q;
                    end
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= read_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= read_data;
                    end
                end
                default: begin
                end
            endcase

            if (pop) begin
                word_count <= word_count + 16'd1;
`ifdef DRAIN_CHECKSUM_EN
                checksum   <= checksum + 16'(head_q);
`endif
            end

            // STALL is entered once the buffer will be full after this edge
            // and left as soon as a pop frees a slot again.
            case (state)
                IDLE: begin
                    if (drain_enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!drain_enable) begin
                        state <= IDLE;
                    end else if (level_next == 2'd2) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (!drain_enable) begin
                        state <= IDLE;
                    end else if (level_next < 2'd2) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_drainer.sv
// tb_fifo_read_drainer
//
// Directed bench for fifo_read_drainer. A small FIFO model answers each
// accepted read with the next stored word on the following cycle; each task
// drives one scenario and checks outputs half a cycle after the rising edge.
// Build with DRAIN_CHECKSUM_EN defined to also check the checksum output.

module tb_fifo_read_drainer;

    logic        clock_read = 1'b0;
    logic        read_reset;
    logic        drain_enable;
    logic        out_ready;
    logic        force_empty;
    logic        empty;
    logic [15:0] read_data = 16'd0;
    logic        read_enable;
    logic [15:0] out_data;
    logic        out_valid;
    logic [15:0] word_count;
`ifdef DRAIN_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] fifo_mem [0:63];
    int          fifo_start = 0;
    int          fifo_len   = 0;
    int          fifo_pops  = 0;
    logic [5:0]  fifo_idx;

    fifo_read_drainer #(.DATA_WIDTH(16)) dut (
        .clock_read   (clock_read),
        .read_reset   (read_reset),
        .drain_enable (drain_enable),
        .empty        (empty),
        .read_data    (read_data),
        .read_enable  (read_enable),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .word_count   (word_count)
`ifdef DRAIN_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clock_read = ~clock_read;

    // FIFO model: empty once every loaded word has been popped, or when a
    // test forces it; a popped word appears on read_data one cycle later.
    assign fifo_idx = 6'(fifo_pops - fifo_start);
    assign empty    = force_empty || ((fifo_pops - fifo_start) >= fifo_len);

    always @(posedge clock_read) begin
        if (read_enable) begin
            read_data <= fifo_mem[fifo_idx];
            fifo_pops <= fifo_pops + 1;
        end
    end

    task automatic load_fifo(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[6'(i)] = first + 16'(i);
        end
        fifo_start = fifo_pops;
        fifo_len   = n;
    endtask

    task automatic apply_reset();
        @(negedge clock_read);
        read_reset   = 1'b1;
        drain_enable = 1'b0;
        out_ready    = 1'b0;
        force_empty  = 1'b1;
        @(negedge clock_read);
        @(negedge clock_read);
        read_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock_read);
        read_reset   = 1'b1;
        drain_enable = 1'b1;
        out_ready    = 1'b1;
        force_empty  = 1'b0;
        load_fifo(16'd900, 4);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (read_enable !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_read_enable cycle %0d: got %b want 0", c, read_enable);
            end
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_out_valid cycle %0d: got %b want 0", c, out_valid);
            end
            tests_run++;
            if (word_count !== 16'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_word_count cycle %0d: got %0d want 0", c, word_count);
            end
            @(negedge clock_read);
        end
        tests_run++;
        if (out_data !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_data: got %0d want 0", out_data);
        end
`ifdef DRAIN_CHECKSUM_EN
        tests_run++;
        if (checksum !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_checksum: got %0d want 0", checksum);
        end
`endif
        drain_enable = 1'b0;
        force_empty  = 1'b1;
        read_reset   = 1'b0;
    endtask

    task automatic test_single_word();
        int re_cnt;
        int re_cyc;
        int ov_cnt;
        int ov_cyc;
        re_cnt = 0;
        re_cyc = -1;
        ov_cnt = 0;
        ov_cyc = -1;
        apply_reset();
        load_fifo(16'd420, 1);
        drain_enable = 1'b1;
        out_ready    = 1'b1;
        force_empty  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (read_enable) begin
                re_cnt++;
                if (re_cyc < 0) re_cyc = c;
            end
            if (out_valid) begin
                ov_cnt++;
                if (ov_cyc < 0) ov_cyc = c;
                tests_run++;
                if (out_data !== 16'd420) begin
                    tests_failed++;
                    $display("[TB] FAIL single_out_data: got %0d want 420", out_data);
                end
            end
            @(negedge clock_read);
        end
        tests_run++;
        if (re_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_read_pulses: got %0d want 1", re_cnt);
        end
        tests_run++;
        if (re_cyc < 0 || ov_cyc - re_cyc != 2) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got %0d cycles want 2", ov_cyc - re_cyc);
        end
        tests_run++;
        if (ov_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_valid_cycles: got %0d want 1", ov_cnt);
        end
        tests_run++;
        if (word_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_word_count: got %0d want 1", word_count);
        end
`ifdef DRAIN_CHECKSUM_EN
        tests_run++;
        if (checksum !== 16'd420) begin
            tests_failed++;
            $display("[TB] FAIL single_checksum: got %0d want 420", checksum);
        end
`endif
    endtask

    task automatic test_burst();
        logic [15:0] expected;
        int first_cyc;
        int last_cyc;
        int delivered;
        expected  = 16'd1;
        first_cyc = -1;
        last_cyc  = -1;
        delivered = 0;
        apply_reset();
        load_fifo(16'd1, 49);
        drain_enable = 1'b1;
        out_ready    = 1'b1;
        force_empty  = 1'b0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                tests_run++;
                if (out_data !== expected) begin
                    tests_failed++;
                    $display("[TB] FAIL burst_data cycle %0d: got %0d want %0d", c, out_data, expected);
                end
                expected = expected + 16'd1;
                delivered++;
            end
            @(negedge clock_read);
        end
        tests_run++;
        if (delivered != 49) begin
            tests_failed++;
            $display("[TB] FAIL burst_count: got %0d want 49", delivered);
        end
        tests_run++;
        if (last_cyc - first_cyc + 1 != 49) begin
            tests_failed++;
            $display("[TB] FAIL burst_contiguous: got span %0d want 49", last_cyc - first_cyc + 1);
        end
        tests_run++;
        if (word_count !== 16'd49) begin
            tests_failed++;
            $display("[TB] FAIL burst_word_count: got %0d want 49", word_count);
        end
`ifdef DRAIN_CHECKSUM_EN
        tests_run++;
        if (checksum !== 16'd1225) begin
            tests_failed++;
            $display("[TB] FAIL burst_checksum: got %0d want 1225", checksum);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [15:0] expected;
        logic [15:0] held_data;
        logic        held;
        int accepted;
        int delivered;
        int max_outstanding;
        logic stall_seen;
        expected        = 16'd101;
        held_data       = 16'd0;
        held            = 1'b0;
        accepted        = 0;
        delivered       = 0;
        max_outstanding = 0;
        stall_seen      = 1'b0;
        apply_reset();
        load_fifo(16'd101, 10);
        drain_enable = 1'b1;
        force_empty  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            #1;
            if (dut.state == 2'd2) stall_seen = 1'b1;
            tests_run++;
            if (dut.state == 2'd2 && read_enable) begin
                tests_failed++;
                $display("[TB] FAIL bp_read_in_stall cycle %0d: got read_enable 1 want 0", c);
            end
            if (out_valid && !out_ready) begin
                if (held) begin
                    tests_run++;
                    if (out_data !== held_data) begin
                        tests_failed++;
                        $display("[TB] FAIL bp_hold_data cycle %0d: got %0d want %0d", c, out_data, held_data);
                    end
                end
                held      = 1'b1;
                held_data = out_data;
            end else begin
                held = 1'b0;
            end
            if (read_enable) accepted++;
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_data !== expected) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_data cycle %0d: got %0d want %0d", c, out_data, expected);
                end
                expected = expected + 16'd1;
                delivered++;
            end
            if (accepted - delivered > max_outstanding) max_outstanding = accepted - delivered;
            @(negedge clock_read);
        end
        tests_run++;
        if (max_outstanding > 2) begin
            tests_failed++;
            $display("[TB] FAIL bp_max_buffered: got %0d want at most 2", max_outstanding);
        end
        tests_run++;
        if (stall_seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_stall_entered: got %b want 1", stall_seen);
        end
        tests_run++;
        if (delivered != 10) begin
            tests_failed++;
            $display("[TB] FAIL bp_count: got %0d want 10", delivered);
        end
        tests_run++;
        if (word_count !== 16'd10) begin
            tests_failed++;
            $display("[TB] FAIL bp_word_count: got %0d want 10", word_count);
        end
    endtask

    task automatic test_control_edges();
        logic [15:0] expected;
        int re_cnt;
        int delivered;
        re_cnt    = 0;
        delivered = 0;
        apply_reset();
        load_fifo(16'd201, 3);
        drain_enable = 1'b1;
        out_ready    = 1'b1;
        force_empty  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) drain_enable = 1'b0;
            #1;
            if (c == 2) begin
                tests_run++;
                if (read_enable !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL ctl_drop_read_enable: got %b want 0", read_enable);
                end
            end
            if (read_enable) re_cnt++;
            if (out_valid) begin
                delivered++;
                tests_run++;
                if (out_data !== 16'd201) begin
                    tests_failed++;
                    $display("[TB] FAIL ctl_inflight_data: got %0d want 201", out_data);
                end
            end
            @(negedge clock_read);
        end
        tests_run++;
        if (re_cnt != 1 || delivered != 1) begin
            tests_failed++;
            $display("[TB] FAIL ctl_inflight_delivered: got reads %0d words %0d want 1 and 1", re_cnt, delivered);
        end
        tests_run++;
        if (dut.state != 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL ctl_idle_after_drop: got state %0d want 0", dut.state);
        end

        expected  = 16'd211;
        delivered = 0;
        load_fifo(16'd211, 6);
        drain_enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            force_empty = (c >= 3 && c <= 5);
            #1;
            if (force_empty) begin
                tests_run++;
                if (read_enable !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL ctl_empty_read_enable cycle %0d: got %b want 0", c, read_enable);
                end
            end
            if (out_valid) begin
                tests_run++;
                if (out_data !== expected) begin
                    tests_failed++;
                    $display("[TB] FAIL ctl_empty_data cycle %0d: got %0d want %0d", c, out_data, expected);
                end
                expected = expected + 16'd1;
                delivered++;
            end
            @(negedge clock_read);
        end
        tests_run++;
        if (delivered != 6) begin
            tests_failed++;
            $display("[TB] FAIL ctl_empty_count: got %0d want 6", delivered);
        end
        tests_run++;
        if (word_count !== 16'd7) begin
            tests_failed++;
            $display("[TB] FAIL ctl_word_count: got %0d want 7", word_count);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] expected;
        int delivered;
        expected  = 16'd301;
        delivered = 0;
        apply_reset();
        load_fifo(16'd301, 20);
        drain_enable = 1'b1;
        out_ready    = 1'b1;
        force_empty  = 1'b0;
        for (int c = 0; c < 30 && delivered < 5; c++) begin
            #1;
            if (out_valid) begin
                tests_run++;
                if (out_data !== expected) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_data cycle %0d: got %0d want %0d", c, out_data, expected);
                end
                expected = expected + 16'd1;
                delivered++;
            end
            @(negedge clock_read);
        end
        tests_run++;
        if (word_count !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL mid_pre_reset_count: got %0d want 5", word_count);
        end
        read_reset = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || read_enable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got valid %b read %b want 0 0", out_valid, read_enable);
        end
        tests_run++;
        if (word_count !== 16'd0 || out_data !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_clear: got count %0d data %0d want 0 0", word_count, out_data);
        end
        @(negedge clock_read);
        read_reset = 1'b0;
        load_fifo(16'd619, 1);
        #1;
        tests_run++;
        if (read_enable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_first_cycle_read: got %b want 0", read_enable);
        end
        delivered = 0;
        @(negedge clock_read);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                delivered++;
                tests_run++;
                if (out_data !== 16'd619) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_new_data: got %0d want 619", out_data);
                end
            end
            @(negedge clock_read);
        end
        tests_run++;
        if (delivered != 1 || word_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL mid_new_count: got words %0d count %0d want 1 1", delivered, word_count);
        end
`ifdef DRAIN_CHECKSUM_EN
        tests_run++;
        if (checksum !== 16'd619) begin
            tests_failed++;
            $display("[TB] FAIL mid_checksum: got %0d want 619", checksum);
        end
`endif
    endtask

    // Safety net so a stuck scenario still ends the run with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        read_reset   = 1'b1;
        drain_enable = 1'b0;
        out_ready    = 1'b0;
        force_empty  = 1'b1;
        test_reset();
        test_single_word();
        test_burst();
        test_backpressure();
        test_control_edges();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_read_drainer.md
FIFO_READ_DRAINER -- requirements
Module: fifo_read_drainer

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of read_data and out_data.
REQ-002 clock_read  input  1  single clock; all state on its rising edge.
REQ-003 read_reset  input  1  asynchronous, active-high reset.
REQ-004 drain_enable  input  1  permits new FIFO reads while high.
REQ-005 empty  input  1  FIFO read-side empty flag, synchronous to clock_read.
REQ-006 read_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-007 read_enable  output  1  FIFO pop request, combinational.
REQ-008 out_data  output  DATA_WIDTH  head of the skid buffer.
REQ-009 out_valid  output  1  out_data holds a word.
REQ-010 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
REQ-011 word_count  output  16  words delivered downstream; wraps 0xFFFF->0x0000.
REQ-012 checksum  output  16  running sum of delivered words, mod 2^16 (present only per REQ-031).

Function
REQ-013 Accepted read = read_enable high on a clock_read edge; the FIFO word arrives on read_data at the next edge, and an inflight flag marks it.
REQ-014 pop = out_valid && out_ready; push = inflight (capture of read_data into buffer).
REQ-015 Skid buffer holds 2 entries, FIFO order; occ is 0..2; out_valid = (occ != 0); out_data = oldest entry.
REQ-016 FSM states: IDLE, RUN, STALL.
REQ-017 IDLE -> RUN when drain_enable=1; RUN -> IDLE when drain_enable=0; RUN -> STALL when occ + inflight - pop == 2 after update; STALL -> RUN when that sum < 2; STALL -> IDLE when drain_enable=0.
REQ-018 read_enable = (state==RUN) && drain_enable && !empty && (occ + inflight - pop < 2).
REQ-019 read_enable never asserts while empty=1, in IDLE or in STALL, or during reset.
REQ-020 Simultaneous push and pop: occ unchanged, new word written behind head; no word lost or duplicated.
REQ-021 Inflight word is always captured, even if drain_enable falls or state leaves RUN.
REQ-022 Sustained throughput with out_ready=1 and empty=0: one word per cycle; first out_valid 2 cycles after first read_enable.
REQ-023 out_data stable and out_valid held while out_valid=1 and out_ready=0.
REQ-024 word_count increments by 1 on each pop, 16-bit wrap.

Reset
REQ-025 read_reset=1 asynchronously forces: state=IDLE, occ=0, inflight=0, out_valid=0, read_enable=0, out_data=0, word_count=0, checksum=0.
REQ-026 Reset mid-transfer discards buffered and inflight words; no read_enable in the first cycle after deassertion.
REQ-027 Release is synchronous to clock_read by the integrator; no internal synchronizer.

Configuration
REQ-028 Macro DRAIN_CHECKSUM_EN selects the checksum feature.
REQ-029 Defined: checksum port exists and adds out_data on every pop, mod 2^16.
REQ-030 Undefined: checksum port and adder absent; all other behaviour identical.
REQ-031 Port list differs only by checksum; REQ-012 applies only when defined.

Verification
REQ-032 Reset: hold read_reset 3 cycles with empty=0, drain_enable=1 -> read_enable=0, out_valid=0, word_count=0 throughout.
REQ-033 Single word: FIFO supplies 420, out_ready=1 -> one read_enable pulse, out_data=420 with out_valid 2 cycles later, word_count=1, checksum=420.
REQ-034 Burst: FIFO supplies 1..49 back-to-back, out_ready=1 -> 49 consecutive out_valid cycles, values 1..49 in order, word_count=49, checksum=1225.
REQ-035 Backpressure: burst of 10 with out_ready=0 for cycles 4-9 -> at most 2 buffered, STALL entered, no read_enable while stalled, all 10 delivered in order.
REQ-036 Control edges: drain_enable dropped with a read inflight -> that word still delivered, then IDLE; empty raised mid-burst -> read_enable low the same cycle, no spurious word.
REQ-037 Reset mid-burst after 5 words -> outputs cleared immediately; after release, new word 619 delivered as word_count=1, checksum=619.
